// File: rtl/tdc_phase_detector_5bit_pkg.sv
// Shared ADPLL definitions: error width, FSM encoding and sign convention
// used by the phase detector and its PI filter.
package tdc_phase_detector_5bit_pkg;

    localparam int ADPLL_ERR_W = 5;

    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;

    typedef enum logic [1:0] {
        ARM      = 2'd0,
        IDLE     = 2'd1,
        REF_LEAD = 2'd2,
        FB_LEAD  = 2'd3
    } tdc_state_e;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes one asynchronous clock input into clk and flags its
// rising edges as a registered single-cycle pulse.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   rise_q;
    logic                   rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/tdc_phase_detector_5bit.sv
// Counter-based TDC phase detector: measures ref/fb edge spacing in clk
// periods and reports a saturating sign-magnitude error to the PI filter.
module tdc_phase_detector_5bit
    import tdc_phase_detector_5bit_pkg::*;
#(
    parameter int WIDTH       = ADPLL_ERR_W,
    parameter int MAX_CNT     = (2 ** WIDTH) - 1,
    parameter int SYNC_STAGES = 2,
    parameter bit HOLD_LAST   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ref_clk_in,
    input  logic             fb_clk_in,
    output logic             error_sign,
    output logic [WIDTH-1:0] error,
    output logic             err_valid,
    output logic             cycle_slip
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX_CNT);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic ref_rise;
    logic fb_rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ref_clk_in),
        .rise  (ref_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .clk   (clk),
        .reset (reset),
        .d     (fb_clk_in),
        .rise  (fb_rise)
    );

    tdc_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             mute_q, mute_d;
    logic [WIDTH-1:0] error_q, error_d;
    logic             sign_q, sign_d;
    logic             valid_q, valid_d;
    logic             slip_q, slip_d;

    logic             emit;
    logic [WIDTH-1:0] emit_mag;
    logic             emit_sign;
    logic             emit_slip;
    logic [WIDTH-1:0] cnt_inc;

    always_comb begin
        cnt_inc   = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mute_d    = mute_q;
        emit      = 1'b0;
        emit_mag  = '0;
        emit_sign = SIGN_POS;
        emit_slip = 1'b0;

        unique case (state_q)
            ARM, IDLE: begin
                if (ref_rise && fb_rise) begin
                    emit    = 1'b1;
                    state_d = IDLE;
                end else if (ref_rise) begin
                    state_d = REF_LEAD;
                    cnt_d   = CNT_ONE;
                end else if (fb_rise) begin
                    state_d = FB_LEAD;
                    cnt_d   = CNT_ONE;
                end
            end
            REF_LEAD: begin
                if (fb_rise) begin
                    emit     = 1'b1;
                    emit_mag = cnt_q;
                    cnt_d    = CNT_ONE;
                    state_d  = ref_rise ? REF_LEAD : IDLE;
                end else if (ref_rise) begin
                    emit      = 1'b1;
                    emit_mag  = CNT_MAX;
                    emit_slip = 1'b1;
                    cnt_d     = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FB_LEAD: begin
                emit_sign = SIGN_NEG;
                if (ref_rise) begin
                    emit     = 1'b1;
                    emit_mag = cnt_q;
                    cnt_d    = CNT_ONE;
                    state_d  = fb_rise ? FB_LEAD : IDLE;
                end else if (fb_rise) begin
                    emit      = 1'b1;
                    emit_mag  = CNT_MAX;
                    emit_slip = 1'b1;
                    cnt_d     = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ARM;
        endcase

        // The first measurement after arming only primes the detector.
        valid_d = emit & ~mute_q;
        slip_d  = emit_slip & ~mute_q;
        if (emit) begin
            mute_d = 1'b0;
        end

        if (emit && !mute_q) begin
            error_d = emit_mag;
            sign_d  = (emit_mag == '0) ? SIGN_POS : emit_sign;
        end else if (HOLD_LAST) begin
            error_d = error_q;
            sign_d  = sign_q;
        end else begin
            error_d = '0;
            sign_d  = SIGN_POS;
        end

        if (!enable) begin
            state_d = ARM;
            cnt_d   = '0;
            mute_d  = 1'b1;
            error_d = '0;
            sign_d  = SIGN_POS;
            valid_d = 1'b0;
            slip_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARM;
            cnt_q   <= '0;
            mute_q  <= 1'b1;
            error_q <= '0;
            sign_q  <= SIGN_POS;
            valid_q <= 1'b0;
            slip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mute_q  <= mute_d;
            error_q <= error_d;
            sign_q  <= sign_d;
            valid_q <= valid_d;
            slip_q  <= slip_d;
        end
    end

    assign error_sign = sign_q;
    assign error      = error_q;
    assign err_valid  = valid_q;
    assign cycle_slip = slip_q;

endmodule

// File: tb/tb_tdc_phase_detector_5bit.sv
// Scoreboard bench: edge-time reference model feeds expectation queues,
// a monitor checks two detectors (HOLD_LAST 0 and 1) every cycle.
module tb_tdc_phase_detector_5bit;

    localparam int MAXC = 31;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       ref_clk_in = 1'b0;
    logic       fb_clk_in = 1'b0;
    logic       s0, s1, v0, v1, c0, c1;
    logic [4:0] e0, e1;

    tdc_phase_detector_5bit #(.HOLD_LAST(1'b0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .ref_clk_in (ref_clk_in),
        .fb_clk_in  (fb_clk_in),
        .error_sign (s0),
        .error      (e0),
        .err_valid  (v0),
        .cycle_slip (c0)
    );

    tdc_phase_detector_5bit #(.HOLD_LAST(1'b1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .ref_clk_in (ref_clk_in),
        .fb_clk_in  (fb_clk_in),
        .error_sign (s1),
        .error      (e1),
        .err_valid  (v1),
        .cycle_slip (c1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        bit sign;
        bit slip;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t held = '{mag: 0, sign: 1'b0, slip: 1'b0};
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lead = 0;
    int   t0 = 0;
    bit   mute = 1'b1;
    bit   ref_prev = 1'b0;
    bit   fb_prev = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int sat(int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic emit(int mag, bit sign, bit slip);
        exp_t e;
        if (mute) begin
            mute = 1'b0;
            return;
        end
        e.mag  = mag;
        e.sign = (mag == 0) ? 1'b0 : sign;
        e.slip = slip;
        q0.push_back(e);
        q1.push_back(e);
    endtask

    // lead: 0 none, 1 ref edge pending, 2 fb edge pending; t0 = its cycle
    task automatic model(bit rr, bit fr);
        bit own;
        bit other;
        bit sg;
        if (!rr && !fr) return;
        if (lead == 0) begin
            if (rr && fr) begin
                emit(0, 1'b0, 1'b0);
            end else begin
                lead = rr ? 1 : 2;
                t0   = cyc;
            end
        end else begin
            own   = (lead == 1) ? rr : fr;
            other = (lead == 1) ? fr : rr;
            sg    = (lead == 2);
            if (other) begin
                emit(sat(cyc - t0), sg, 1'b0);
                if (own) t0 = cyc;
                else lead = 0;
            end else begin
                emit(MAXC, sg, 1'b1);
                t0 = cyc;
            end
        end
    endtask

    task automatic step(bit r, bit f, bit en, bit rst);
        @(negedge clk);
        cyc++;
        ref_clk_in = r;
        fb_clk_in  = f;
        enable     = en;
        reset      = rst;
        if (rst || !en) begin
            lead = 0;
            mute = 1'b1;
        end else begin
            model(r & ~ref_prev, f & ~fb_prev);
        end
        ref_prev = r;
        fb_prev  = f;
    endtask

    function automatic bit hit(int i, int t);
        return (t >= 0) && (i >= t) && (i < t + 2);
    endfunction

    task automatic win(int len, int r0, int r1, int f0, int f1,
                       int off = -1, int on = -1, int rst_at = -1);
        bit r, f, en, rs;
        for (int i = 0; i < len; i++) begin
            r  = hit(i, r0) || hit(i, r1);
            f  = hit(i, f0) || hit(i, f1);
            en = !(off >= 0 && i >= off && i < on);
            rs = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + 2);
            step(r, f, en, rs);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset || !enable) begin
            held = '{mag: 0, sign: 1'b0, slip: 1'b0};
            chk("off_out0", int'({v0, c0, s0, e0}), 0);
            chk("off_out1", int'({v1, c1, s1, e1}), 0);
        end else begin
            if (v0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_strobe0", int'(e0), -1);
                end else begin
                    e = q0.pop_front();
                    chk("error0", int'(e0), e.mag);
                    chk("sign0", int'(s0), int'(e.sign));
                    chk("slip0", int'(c0), int'(e.slip));
                end
            end else begin
                chk("quiet0", int'({c0, s0, e0}), 0);
            end
            if (v1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_strobe1", int'(e1), -1);
                end else begin
                    e = q1.pop_front();
                    chk("error1", int'(e1), e.mag);
                    chk("sign1", int'(s1), int'(e.sign));
                    chk("slip1", int'(c1), int'(e.slip));
                    held = e;
                end
            end else begin
                chk("hold1", int'({c1, s1, e1}),
                    int'(held.sign) * 32 + held.mag);
            end
        end
    end

    initial begin
        int kind, d, g, h, o;
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) win(40, 0, -1, 0, -1);
        win(40, 0, -1, 7, -1);
        win(40, 12, -1, 0, -1);
        win(60, 0, -1, 45, -1);
        win(40, 0, 20, 25, -1);
        win(40, 0, -1, 9, -1);

        win(40, 0, -1, -1, -1, 10, 20);
        win(40, 0, -1, 7, -1);
        win(40, 0, -1, 3, -1);

        win(40, 0, -1, -1, -1, -1, -1, 10);
        win(40, 14, -1, 0, -1);
        win(40, 14, -1, 0, -1);

        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 9));
            g    = int'($urandom_range(4, 40));
            h    = int'($urandom_range(1, 40));
            if (kind < 6) begin
                d = int'($urandom_range(0, 100)) - 50;
                if (d >= 0)
                    win(d + 12 + int'($urandom_range(0, 8)), 0, -1, d, -1);
                else
                    win(-d + 12 + int'($urandom_range(0, 8)), -d, -1, 0, -1);
            end else if (kind == 6) begin
                win(20, 0, -1, 0, -1);
            end else if (kind == 7) begin
                win(g + h + 10, 0, g, g + h, -1);
            end else if (kind == 8) begin
                win(g + h + 10, g + h, -1, 0, g);
            end else begin
                o = int'($urandom_range(6, 30));
                win(o + 20, 0, -1, -1, -1, o, o + int'($urandom_range(2, 10)));
            end
        end

        repeat (20) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
